// File: rtl/fir_serializer.sv
// fir_serializer: FIFO-buffered parallel-to-serial output stage, LSB first, valid/ready on both sides
module fir_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic [DATA_WIDTH-1:0]         i_word,
  input  logic                          i_word_valid,
  output logic                          o_word_ready,
  output logic                          o_dout,
  output logic                          o_dout_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic push, pop, xfer, last;
  logic [LW-1:0] level_nxt;
  assign o_dout = shift_reg[0];
  // handshake qualifiers; a pop only happens when the shifter is free or finishing its last bit
  always_comb begin
    push      = i_en && i_word_valid && o_word_ready;
    xfer      = i_en && o_dout_valid && i_ready;
    last      = xfer && cnt == CW'(DATA_WIDTH - 1);
    pop       = i_en && o_level != '0 && (state == IDLE || last);
    level_nxt = o_level + LW'(push) - LW'(pop);
  end
  // word storage, written on an accepted push
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_word;
  end
  // pointers, level, registered ready, and the shifter FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      shift_reg    <= '0;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_level      <= '0;
      o_word_ready <= 1'b1;
      o_dout_valid <= 1'b0;
    end else if (i_en) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_level      <= level_nxt;
      o_word_ready <= level_nxt != LW'(FIFO_DEPTH);
      if (pop) begin
        shift_reg    <= mem[rd_ptr];
        cnt          <= '0;
        state        <= SHIFT;
        o_dout_valid <= 1'b1;
      end else if (xfer) begin
        shift_reg <= shift_reg >> 1;
        cnt       <= last ? '0 : cnt + 1'b1;
        if (last) begin
          state        <= IDLE;
          o_dout_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_serializer.sv
// tb_fir_serializer: directed tests plus a cycle-level queue model of the serializer
module tb_fir_serializer;
  localparam int DW = 16;
  localparam int FD = 4;
  logic tb_clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b0, word_valid = 1'b0, rdy = 1'b0;
  logic [DW-1:0] word = '0;
  logic word_ready, dout, dout_valid;
  logic [$clog2(FD):0] level;
  int passed = 0, total = 0;
  logic [DW-1:0] mq[$];
  bit busy = 0;
  logic [DW-1:0] msh = '0;
  int mnb = 0;
  bit xf, lst, cp;
  logic [DW-1:0] rx[$];
  logic [DW-1:0] acc = '0;
  int nbits = 0, bits_total = 0, max_level = 0;
  bit done = 0;

  always #5 tb_clk = ~tb_clk;

  fir_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .i_clk(tb_clk), .i_rst_n(rst_n), .i_en(en), .i_word(word), .i_word_valid(word_valid),
    .o_word_ready(word_ready), .o_dout(dout), .o_dout_valid(dout_valid), .i_ready(rdy), .o_level(level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // model: a word queue plus one shifter slot; compared, received and advanced mid-cycle
  initial forever begin
    @(negedge tb_clk);
    if (!rst_n) begin
      mq.delete();
      busy = 0;
      mnb = 0;
      nbits = 0;
      chk("rst_valid", dout_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_ready", word_ready, 1);
      chk("rst_dout", dout, 0);
    end else begin
      chk("valid", dout_valid, busy);
      if (busy) chk("dout", dout, msh[mnb]);
      chk("level", level, mq.size());
      chk("ready", word_ready, mq.size() != FD);
      if (int'(level) > max_level) max_level = int'(level);
      if (en && dout_valid && rdy) begin
        acc[nbits] = dout;
        nbits++;
        bits_total++;
        if (nbits == DW) begin
          rx.push_back(acc);
          nbits = 0;
        end
      end
      if (en) begin
        cp = mq.size() != FD;
        xf = busy && rdy;
        lst = xf && mnb == DW - 1;
        if (xf) mnb++;
        if (mq.size() > 0 && (!busy || lst)) begin
          msh = mq.pop_front();
          busy = 1;
          mnb = 0;
        end else if (lst) busy = 0;
        if (word_valid && cp) mq.push_back(word);
      end
    end
  end

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    bit ok;
    ok = 0;
    word = w;
    word_valid = 1;
    for (int i = 0; i < 500 && !ok; i++) begin
      ok = en && word_ready;
      tick();
    end
    word_valid = 0;
    chk("push_accepted", ok, 1);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 3000 && rx.size() < n; i++) tick();
    chk("rx_arrived", rx.size() >= n, 1);
  endtask

  initial begin
    logic [DW-1:0] b, hw, v;
    int n0, bt;
    tick();
    tick();
    rst_n = 1;
    en = 1;
    tick();
    // single word, consumer always ready
    rdy = 1;
    push_word(16'hA5C3);
    chk("t1_valid_at_push", dout_valid, 0);
    tick();
    chk("t1_valid_rise", dout_valid, 1);
    for (int i = 0; i < DW; i++) begin
      b[i] = dout;
      chk("t1_valid_hold", dout_valid, 1);
      tick();
    end
    chk("t1_word", b, 16'hA5C3);
    chk("t1_idle", dout_valid, 0);
    // back-pressure with i_ready pattern 1,0,0
    n0 = rx.size();
    bt = bits_total;
    rdy = 0;
    push_word(16'h8001);
    for (int k = 0; k < 300 && rx.size() == n0; k++) begin
      rdy = (k % 3 == 0);
      tick();
    end
    rdy = 0;
    tick();
    tick();
    chk("t2_rx", rx.size(), n0 + 1);
    chk("t2_word", rx[rx.size() - 1], 16'h8001);
    chk("t2_bits", bits_total - bt, 16);
    // fill to full, then drain contiguously
    for (int w = 1; w <= 5; w++) push_word(DW'(w));
    chk("t3_ready", word_ready, 0);
    chk("t3_level", level, 4);
    n0 = rx.size();
    rdy = 1;
    for (int i = 0; i < 80; i++) begin
      chk("t3_contig", dout_valid, 1);
      tick();
    end
    chk("t3_idle", dout_valid, 0);
    chk("t3_count", rx.size(), n0 + 5);
    for (int i = 0; i < 5; i++) chk("t3_order", rx[n0 + i], i + 1);
    // wrap-around with random gaps and random back-pressure
    n0 = rx.size();
    max_level = 0;
    done = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          for (int g = $urandom_range(0, 2); g > 0; g--) tick();
          v = DW'(32'h1111 * (k % 16));
          push_word(v);
        end
        wait_rx(n0 + 20);
        done = 1;
      end
      begin
        while (!done) begin
          rdy = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    rdy = 0;
    tick();
    chk("t4_count", rx.size(), n0 + 20);
    for (int k = 0; k < 20 && n0 + k < rx.size(); k++) chk("t4_word", rx[n0 + k], 32'h1111 * (k % 16));
    chk("t4_max_level", max_level <= 4, 1);
    // reset in the middle of a word
    rdy = 1;
    push_word(16'hFFFF);
    tick();
    for (int i = 0; i < 7; i++) tick();
    rst_n = 0;
    #1;
    chk("t5_rst_valid", dout_valid, 0);
    chk("t5_rst_level", level, 0);
    tick();
    rst_n = 1;
    n0 = rx.size();
    push_word(16'h0F0F);
    wait_rx(n0 + 1);
    chk("t5_word", rx[n0], 16'h0F0F);
    // enable dropped mid-word, with a push attempt that must be ignored
    hw = 16'h3C5A;
    n0 = rx.size();
    push_word(hw);
    tick();
    for (int i = 0; i < 5; i++) tick();
    en = 0;
    word = 16'h1234;
    word_valid = 1;
    for (int i = 0; i < 10; i++) begin
      chk("t6_dout", dout, hw[5]);
      chk("t6_valid", dout_valid, 1);
      chk("t6_level", level, 0);
      tick();
    end
    word_valid = 0;
    en = 1;
    wait_rx(n0 + 1);
    chk("t6_word", rx[n0], hw);
    chk("t6_count", rx.size(), n0 + 1);
    rdy = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
